// File: rtl/mux_scan_pkg.sv
// Shared types and widths for the mux scan controller.
// State encodings, channel geometry and stall counter width.
package mux_scan_pkg;

    localparam int N_CHAN  = 4;
    localparam int CHAN_W  = 2;
    localparam int STALL_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_controller_if.sv
// Sample handshake bundle between the scan controller and its consumer.
// master drives sample data; slave returns sample_ready.
interface mux_scan_controller_if
    import mux_scan_pkg::*;
();

    logic              sample;
    logic [CHAN_W-1:0] sample_chan;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample,
        output sample_chan,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_chan,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/mux_scan_controller_rr_arbiter4.sv
// Combinational round-robin pick over four requests.
// Scans last+1 .. last+4 (mod 4) and returns the first requester.
module rr_arbiter4
    import mux_scan_pkg::*;
(
    input  logic [N_CHAN-1:0] req,
    input  logic [CHAN_W-1:0] last,
    output logic [CHAN_W-1:0] grant,
    output logic              any
);

    logic              found;
    logic [CHAN_W-1:0] idx;

    always_comb begin
        grant = last;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int i = 1; i <= N_CHAN; i++) begin
            idx = last + CHAN_W'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_controller.sv
// Round-robin 4:1 mux scan sequencer with settle window and sample handshake.
// Define MUX_SCAN_STALL_CNT_EN to build the saturating backpressure counter.
module mux_scan_controller
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [N_CHAN-1:0]   req,
    output logic                addr0,
    output logic                addr1,
    input  logic                mux_out,
    mux_scan_controller_if.master snk,
    output logic                busy,
    output logic [STALL_W-1:0]  stall_cnt
);

    localparam logic [7:0] RELOAD = 8'(DWELL - 1);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        cnt;
    logic [CHAN_W-1:0] sel;
    logic [CHAN_W-1:0] last_grant;
    logic [CHAN_W-1:0] grant;
    logic              any;
    logic              go;

    rr_arbiter4 u_arb (
        .req   (req),
        .last  (last_grant),
        .grant (grant),
        .any   (any)
    );

    assign go    = enable && any;
    assign addr0 = sel[0];
    assign addr1 = sel[1];
    assign busy  = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = SETTLE;
            SETTLE:  if (cnt == 8'd0) state_nx = VALID;
            VALID:   if (snk.sample_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            sel              <= '0;
            last_grant       <= 2'd3;
            snk.sample       <= 1'b0;
            snk.sample_chan  <= '0;
            snk.sample_valid <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        sel <= grant;
                        cnt <= RELOAD;
                    end
                end
                SETTLE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        snk.sample       <= mux_out;
                        snk.sample_chan  <= sel;
                        snk.sample_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (snk.sample_ready) begin
                        snk.sample_valid <= 1'b0;
                        last_grant       <= sel;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUX_SCAN_STALL_CNT_EN
    // Saturating count of cycles the consumer held off a valid sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (state == VALID && !snk.sample_ready
                     && stall_cnt != {STALL_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller with a behavioural 4:1 mux.
// Expected values are hand-derived from the sequencing rules.
module tb_mux_scan_controller;
    import mux_scan_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [3:0]        req;
    logic              addr0;
    logic              addr1;
    logic              mux_out;
    logic              busy;
    logic [7:0]        stall_cnt;
    logic [3:0]        din;
    logic [1:0]        a;

    int total = 0;
    int bad   = 0;

    mux_scan_controller_if sif ();

    mux_scan_controller #(.DWELL(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .mux_out   (mux_out),
        .snk       (sif.master),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    assign a       = {addr1, addr0};
    assign mux_out = din[a];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        enable           = 1'b0;
        req              = 4'b0000;
        sif.sample_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Accept edge is edge 1; valid must appear on edge 5 (DWELL+1).
    task automatic to_valid(input logic [1:0] ch, input logic s,
                            input bit drop);
        int n;
        step();
        chk("addr_after_accept", 32'(a), 32'(ch));
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (drop) req = 4'b0000;
        n = 1;
        while (!sif.sample_valid && n < 20) begin
            step();
            n++;
        end
        chk("valid_latency", 32'(n), 32'd5);
        chk("sample", 32'(sif.sample), 32'(s));
        chk("sample_chan", 32'(sif.sample_chan), 32'(ch));
    endtask

    task automatic run_one(input logic [1:0] ch, input logic s);
        to_valid(ch, s, 1'b0);
        step();
        chk("valid_drop", 32'(sif.sample_valid), 32'd0);
        chk("idle_bubble", 32'(busy), 32'd0);
    endtask

    initial begin
        din = 4'b0000;

        // reset with everything requesting
        reset_n          = 1'b0;
        enable           = 1'b1;
        req              = 4'b1111;
        sif.sample_ready = 1'b1;
        step();
        step();
        chk("rst_addr", 32'(a), 32'd0);
        chk("rst_sample", 32'(sif.sample), 32'd0);
        chk("rst_chan", 32'(sif.sample_chan), 32'd0);
        chk("rst_valid", 32'(sif.sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        reset_n = 1'b1;
        din     = 4'b0001;
        run_one(2'd0, 1'b1);

        // single channel 2
        do_reset();
        din              = 4'b0100;
        enable           = 1'b1;
        req              = 4'b0100;
        sif.sample_ready = 1'b1;
        run_one(2'd2, 1'b1);

        // round-robin wrap, inputs 0,1,0,1
        do_reset();
        din              = 4'b1010;
        enable           = 1'b1;
        req              = 4'b1111;
        sif.sample_ready = 1'b1;
        run_one(2'd0, 1'b0);
        run_one(2'd1, 1'b1);
        run_one(2'd2, 1'b0);
        run_one(2'd3, 1'b1);
        run_one(2'd0, 1'b0);

        // backpressure for 10 cycles
        do_reset();
        din              = 4'b1000;
        enable           = 1'b1;
        req              = 4'b1000;
        sif.sample_ready = 1'b0;
        to_valid(2'd3, 1'b1, 1'b0);
        din = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 32'(sif.sample_valid), 32'd1);
            chk("bp_sample", 32'(sif.sample), 32'd1);
            chk("bp_chan", 32'(sif.sample_chan), 32'd3);
            chk("bp_addr", 32'(a), 32'd3);
        end
`ifdef MUX_SCAN_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd10);
`else
        chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        sif.sample_ready = 1'b1;
        step();
        chk("bp_release", 32'(sif.sample_valid), 32'd0);

        // request withdrawn during settle
        do_reset();
        din              = 4'b0010;
        enable           = 1'b1;
        req              = 4'b0010;
        sif.sample_ready = 1'b1;
        to_valid(2'd1, 1'b1, 1'b1);
        step();
        chk("drop_valid", 32'(sif.sample_valid), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        step();
        chk("drop_stay_idle", 32'(busy), 32'd0);

        // reset mid-settle, then enable low
        do_reset();
        din              = 4'b0100;
        enable           = 1'b1;
        req              = 4'b0100;
        sif.sample_ready = 1'b1;
        step();
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(sif.sample_valid), 32'd0);
        chk("abort_addr", 32'(a), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b0;
        req     = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("dis_busy", 32'(busy), 32'd0);
            chk("dis_valid", 32'(sif.sample_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
